// File: rtl/viterbi_pkg.sv
// Shared convolutional-code definitions used by the encoder framer and the Viterbi core.
// Code parameters, the framer FSM state type and the tap-parity helper live here.
package viterbi_pkg;

    localparam int unsigned VIT_K      = 3;
    localparam int unsigned VIT_M      = VIT_K - 1;
    localparam int unsigned VIT_S      = 1 << VIT_M;
    localparam logic [7:0]  VIT_G0_OCT = 8'o07;
    localparam logic [7:0]  VIT_G1_OCT = 8'o05;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2
    } vit_state_e;

    // Taps are right-aligned: bit K-1 is the current input, bit 0 the oldest state bit.
    function automatic logic tap_parity(input logic [7:0] g, input logic [7:0] taps);
        return ^(g & taps);
    endfunction

endpackage

// File: rtl/conv_enc_framer_if.sv
// Information-bit and coded-symbol handshakes of the encoder framer.
// master = upstream/downstream environment, slave = the framer itself.
interface conv_enc_framer_if;

    logic       info_valid;
    logic       info_ready;
    logic       info_bit;
    logic       sym_valid;
    logic       sym_ready;
    logic [1:0] sym;
    logic       sym_last;

    modport master (
        output info_valid, info_bit, sym_ready,
        input  info_ready, sym_valid, sym, sym_last
    );

    modport slave (
        input  info_valid, info_bit, sym_ready,
        output info_ready, sym_valid, sym, sym_last
    );

endinterface

// File: rtl/conv_enc_parity.sv
// Combinational rate-1/2 parity: sym[1] = y0 from G0, sym[0] = y1 from G1.
// i_sr[K-2] is the most recent previous input bit.
module conv_enc_parity
    import viterbi_pkg::*;
#(
    parameter int unsigned K      = VIT_K,
    parameter logic [7:0]  G0_OCT = VIT_G0_OCT,
    parameter logic [7:0]  G1_OCT = VIT_G1_OCT
) (
    input  logic         i_u,
    input  logic [K-2:0] i_sr,
    output logic [1:0]   o_sym
);

    logic [7:0] w_taps;

    always_comb begin
        w_taps          = '0;
        w_taps[K-1:0]   = {i_u, i_sr};
    end

    assign o_sym = {tap_parity(G0_OCT, w_taps), tap_parity(G1_OCT, w_taps)};

endmodule

// File: rtl/conv_enc_framer.sv
// Framed convolutional encoder: L_FRAME info bits plus M zero tail bits per frame,
// one-deep output register. Optional macro CONV_ENC_ERR_INJ_EN adds the err_flip input.
module conv_enc_framer
    import viterbi_pkg::*;
#(
    parameter int unsigned K       = VIT_K,
    parameter logic [7:0]  G0_OCT  = VIT_G0_OCT,
    parameter logic [7:0]  G1_OCT  = VIT_G1_OCT,
    parameter int unsigned L_FRAME = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
`ifdef CONV_ENC_ERR_INJ_EN
    input  logic [1:0]          err_flip,
`endif
    output logic                busy,
    conv_enc_framer_if.slave    bus
);

    localparam int unsigned M         = K - 1;
    localparam logic [15:0] LAST_BIT  = 16'(L_FRAME - 1);
    localparam logic [7:0]  LAST_TAIL = 8'(M - 1);

    vit_state_e  r_state;
    vit_state_e  w_state_next;
    logic [M-1:0] r_sr;
    logic [M-1:0] w_sr_next;
    logic [15:0] r_bit_cnt;
    logic [7:0]  r_tail_cnt;
    logic        r_sym_valid;
    logic        r_sym_last;
    logic [1:0]  r_sym;

    logic        w_slot_free;
    logic        w_start;
    logic        w_load_data;
    logic        w_load_tail;
    logic        w_load;
    logic        w_is_last;
    logic        w_u;
    logic [1:0]  w_par;
    logic [1:0]  w_err;

`ifdef CONV_ENC_ERR_INJ_EN
    assign w_err = err_flip;
`else
    assign w_err = '0;
`endif

    // Output register can take a new symbol when empty or being drained this cycle.
    assign w_slot_free    = !r_sym_valid || bus.sym_ready;
    assign bus.info_ready = (r_state == ST_DATA) && w_slot_free;
    assign w_u            = (r_state == ST_DATA) ? bus.info_bit : 1'b0;
    assign w_load         = w_load_data || w_load_tail;
    assign w_is_last      = w_load_tail && (r_tail_cnt == LAST_TAIL);
    assign w_sr_next      = M'({w_u, r_sr} >> 1);

    conv_enc_parity #(
        .K      (K),
        .G0_OCT (G0_OCT),
        .G1_OCT (G1_OCT)
    ) u_parity (
        .i_u   (w_u),
        .i_sr  (r_sr),
        .o_sym (w_par)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_load_data  = 1'b0;
        w_load_tail  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frame_start) begin
                    w_start      = 1'b1;
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.info_valid && w_slot_free) begin
                    w_load_data = 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_next = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                if (w_slot_free) begin
                    w_load_tail = 1'b1;
                    if (r_tail_cnt == LAST_TAIL) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // A frame may open while the previous last symbol is still pending; the
    // output register is left alone and only the encoder state is cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_tail_cnt  <= '0;
            r_sym_valid <= 1'b0;
            r_sym_last  <= 1'b0;
            r_sym       <= '0;
        end else begin
            if (w_start) begin
                r_sr       <= '0;
                r_bit_cnt  <= '0;
                r_tail_cnt <= '0;
            end else if (w_load) begin
                r_sr <= w_sr_next;
            end

            if (w_load_data) begin
                r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + 16'd1;
            end
            if (w_load_tail) begin
                r_tail_cnt <= w_is_last ? '0 : r_tail_cnt + 8'd1;
            end

            if (w_load) begin
                r_sym       <= w_par ^ w_err;
                r_sym_valid <= 1'b1;
                r_sym_last  <= w_is_last;
            end else if (bus.sym_ready) begin
                r_sym_valid <= 1'b0;
                r_sym_last  <= 1'b0;
            end
        end
    end

    assign bus.sym       = r_sym;
    assign bus.sym_valid = r_sym_valid;
    assign bus.sym_last  = r_sym_last;
    assign busy          = (r_state != ST_IDLE) || r_sym_valid;

endmodule

// File: tb/tb_conv_enc_framer.sv
// Self-checking bench for conv_enc_framer (K=3, G=7/5, L_FRAME=12) against a
// convolution-sum reference model with per-cycle comparison of all outputs.
module tb_conv_enc_framer;

    localparam int          L   = 12;
    localparam int          KK  = 3;
    localparam int          MM  = 2;
    localparam logic [7:0]  G0  = 8'o07;
    localparam logic [7:0]  G1  = 8'o05;

    typedef struct {
        logic [1:0] s;
        logic       last;
    } exp_t;

    typedef struct {
        logic [1:0] s;
        logic       last;
        int         c;
    } log_t;

    logic       clk;
    logic       rst;
    logic       frame_start;
    logic       busy;
    logic [1:0] err_flip;

    conv_enc_framer_if ifc ();

    conv_enc_framer #(
        .K       (KK),
        .G0_OCT  (G0),
        .G1_OCT  (G1),
        .L_FRAME (L)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
`ifdef CONV_ENC_ERR_INJ_EN
        .err_flip    (err_flip),
`endif
        .busy        (busy),
        .bus         (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   rdy_mode = 0;

    // Reference model state
    bit   started    = 0;
    bit   data_phase = 0;
    int   tail_left  = 0;
    int   occ        = 0;
    int   nbits      = 0;
    int   sym_cnt    = 0;
    bit   fbits[$];
    exp_t expq[$];
    log_t acc_log[$];

    bit   ev, acc, fbit, ftail, fstart;
    exp_t e;

    logic [1:0] dir_exp [14];
    bit         dir_bits [L];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout, got no progress expected completion (cycle %0d)", name, cyc);
    endtask

    // Encoder output as a convolution over the frame's input history (zeros before the frame).
    function automatic logic [1:0] enc(input int n);
        logic y0, y1;
        y0 = 1'b0;
        y1 = 1'b0;
        for (int j = 0; j <= MM; j++) begin
            if (n - j >= 0 && fbits[n - j]) begin
                y0 ^= G0[KK - 1 - j];
                y1 ^= G1[KK - 1 - j];
            end
        end
        return {y0, y1};
    endfunction

    // Compare, then advance the model with the handshakes that fire at the next edge.
    always @(negedge clk) begin
        cyc++;
        if (started) begin
            ev = (occ > 0);
            check("sym_valid", ifc.sym_valid, ev);
            check("busy", busy, data_phase || tail_left > 0 || ev);
            check("info_ready", ifc.info_ready, data_phase && (!ev || ifc.sym_ready));
            if (ev && expq.size() > 0) begin
                check("sym", ifc.sym, expq[0].s);
                check("sym_last", ifc.sym_last, expq[0].last);
            end
        end
        if (rst) begin
            started    = 1;
            data_phase = 0;
            tail_left  = 0;
            occ        = 0;
            nbits      = 0;
            sym_cnt    = 0;
            fbits.delete();
            expq.delete();
        end else if (started) begin
            ev     = (occ > 0);
            acc    = ev && ifc.sym_ready;
            fbit   = data_phase && ifc.info_valid && (!ev || ifc.sym_ready);
            ftail  = (tail_left > 0) && (!ev || ifc.sym_ready);
            fstart = frame_start && !data_phase && tail_left == 0;
            if (acc && expq.size() > 0) begin
                e = expq.pop_front();
                acc_log.push_back('{s: ifc.sym, last: ifc.sym_last, c: cyc});
                occ--;
                sym_cnt++;
                if (e.last) begin
                    check("frame_sym_count", sym_cnt, L + MM);
                    sym_cnt = 0;
                end
            end
            if (fbit) begin
                fbits.push_back(ifc.info_bit);
                expq.push_back('{s: enc(fbits.size() - 1), last: 1'b0});
                occ++;
                nbits++;
                if (nbits == L) begin
                    data_phase = 0;
                    tail_left  = MM;
                end
            end
            if (ftail) begin
                fbits.push_back(1'b0);
                expq.push_back('{s: enc(fbits.size() - 1), last: (tail_left == 1)});
                tail_left--;
                occ++;
            end
            if (fstart) begin
                data_phase = 1;
                nbits      = 0;
                fbits.delete();
            end
        end
    end

    initial begin
        ifc.sym_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       ifc.sym_ready = 1'b1;
                1:       ifc.sym_ready = ($urandom_range(0, 3) != 0);
                default: ifc.sym_ready = 1'b0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit directed, input bit do_start, input int stop_after,
                              input int stall_at);
        int budget;
        bit stalled;
        int rdy_save;
        budget  = 0;
        stalled = 0;
        if (do_start) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
        end
        while (data_phase && nbits < stop_after && budget < 2000) begin
            if (directed) begin
                ifc.info_valid = 1'b1;
                ifc.info_bit   = dir_bits[nbits];
            end else begin
                ifc.info_valid = ($urandom_range(0, 3) != 0);
                ifc.info_bit   = 1'($urandom_range(0, 1));
                frame_start    = ($urandom_range(0, 9) == 0);
            end
            if (stall_at >= 0 && nbits == stall_at && !stalled) begin
                stalled        = 1;
                ifc.info_valid = 1'b1;
                rdy_save       = rdy_mode;
                rdy_mode       = 2;
                repeat (5) tick();
                check("stall_info_ready", ifc.info_ready, 1'b0);
                check("stall_sym_valid", ifc.sym_valid, 1'b1);
                rdy_mode = rdy_save;
            end
            tick();
            budget++;
        end
        ifc.info_valid = 1'b0;
        frame_start    = 1'b0;
        if (budget >= 2000) timeout("send_frame");
    endtask

    task automatic wait_drain(input bit pulses);
        int budget;
        budget = 0;
        while (!( !data_phase && tail_left == 0 && occ == 0) && budget < 500) begin
            frame_start = pulses && (data_phase || tail_left > 0) && ($urandom_range(0, 4) == 0);
            tick();
            budget++;
        end
        frame_start = 1'b0;
        if (budget >= 500) timeout("wait_drain");
    endtask

    task automatic check_directed();
        check("dir_count", acc_log.size(), 14);
        for (int i = 0; i < 14 && i < acc_log.size(); i++) begin
            check($sformatf("dir_sym%0d", i), acc_log[i].s, dir_exp[i]);
            check($sformatf("dir_last%0d", i), acc_log[i].last, (i == 13));
            if (i > 0) check($sformatf("dir_thru%0d", i), acc_log[i].c - acc_log[i-1].c, 1);
        end
    endtask

    initial begin
        // Info 1,0,1,1 then zeros: 11,10,00,01 then 01,11 flush, then all 00.
        dir_exp = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00,
                    2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        foreach (dir_bits[i]) dir_bits[i] = 1'b0;
        dir_bits[0] = 1'b1;
        dir_bits[2] = 1'b1;
        dir_bits[3] = 1'b1;

        rst            = 1'b1;
        frame_start    = 1'b0;
        err_flip       = 2'b00;
        ifc.info_valid = 1'b0;
        ifc.info_bit   = 1'b0;
        repeat (3) tick();
        check("rst_sym_valid", ifc.sym_valid, 1'b0);
        check("rst_sym", ifc.sym, 2'b00);
        check("rst_sym_last", ifc.sym_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_info_ready", ifc.info_ready, 1'b0);
        rst = 1'b0;
        tick();

        // Known frame at full throughput
        rdy_mode = 0;
        acc_log.delete();
        send_frame(1, 1, L, -1);
        wait_drain(0);
        check_directed();

        // Output stall mid-frame
        rdy_mode = 0;
        send_frame(0, 1, L, 5);
        wait_drain(1);

        // Reset after 10 info bits, then the same frame again from state 0
        rdy_mode = 1;
        send_frame(1, 1, 10, -1);
        rst = 1'b1;
        tick();
        check("midrst_sym_valid", ifc.sym_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        tick();
        acc_log.delete();
        rdy_mode = 0;
        send_frame(1, 1, L, -1);
        wait_drain(0);
        check_directed();

        // New frame opened while the previous last symbol is still pending
        rdy_mode = 0;
        send_frame(0, 1, L, -1);
        begin
            int budget;
            budget = 0;
            while (tail_left > 0 && budget < 100) begin
                tick();
                budget++;
            end
            if (budget >= 100) timeout("tail_wait");
        end
        rdy_mode    = 2;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("pend_sym_valid", ifc.sym_valid, 1'b1);
        check("pend_sym_last", ifc.sym_last, 1'b1);
        check("pend_info_ready", ifc.info_ready, 1'b0);
        check("pend_busy", busy, 1'b1);
        rdy_mode = 1;
        send_frame(0, 0, L, -1);
        wait_drain(1);

        // Randomized frames with stray frame_start pulses
        repeat (15) begin
            rdy_mode = $urandom_range(0, 1);
            send_frame(0, 1, L, -1);
            wait_drain(1);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
